mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 106 ++++++++++
 tb/tb_mc_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle RISC-V control FSM; define ILLEGAL_TRAP_EN to trap on unknown opcodes
module mc_control #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic [31:0] instr_q,
  output logic [2:0]  state,
  output logic        alu_src_imm,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        reg_we,
  output logic        illegal_instr,
  output logic        bus_err
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic [7:0]  r_wait;
  logic        r_bus;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_imm, w_op, w_known;
  logic        w_wait_cyc, w_timeout;
  assign w_lui   = r_instr[6:0] == 7'b0110111;
  assign w_auipc = r_instr[6:0] == 7'b0010111;
  assign w_jal   = r_instr[6:0] == 7'b1101111;
  assign w_jalr  = r_instr[6:0] == 7'b1100111;
  assign w_br    = r_instr[6:0] == 7'b1100011;
  assign w_ld    = r_instr[6:0] == 7'b0000011;
  assign w_st    = r_instr[6:0] == 7'b0100011;
  assign w_imm   = r_instr[6:0] == 7'b0010011;
  assign w_op    = r_instr[6:0] == 7'b0110011;
  assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_imm | w_op;
  // a waiting cycle is a FETCH/MEM cycle without its ack; the MAX_WAIT-th such cycle still accepts ack
  assign w_wait_cyc = (r_state == S_FETCH && !imem_ack) || (r_state == S_MEM && !dmem_ack);
  assign w_timeout  = w_wait_cyc && (r_wait == 8'(MAX_WAIT - 1));
  // next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = imem_ack ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_DECODE: w_next = w_known ? S_EXEC : S_TRAP;
`else
      S_DECODE: w_next = w_known ? S_EXEC : S_WB;
`endif
      S_EXEC:   w_next = (w_ld | w_st) ? S_MEM : w_br ? S_FETCH : S_WB;
      S_MEM:    w_next = dmem_ack ? (w_ld ? S_WB : S_FETCH) : w_timeout ? S_TRAP : S_MEM;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end
  // state, instruction register, wait counter and bus-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_wait  <= '0;
      r_bus   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_instr <= (r_state == S_FETCH && imem_ack) ? imem_rdata : r_instr;
      r_wait  <= (w_wait_cyc && !w_timeout) ? r_wait + 8'd1 : 8'd0;
      r_bus   <= r_bus | w_timeout;
    end
  end
`ifdef ILLEGAL_TRAP_EN
  logic r_ill;
  // sticky flag for an unknown opcode reaching DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ill <= 1'b0;
    else        r_ill <= r_ill | (r_state == S_DECODE && !w_known);
  end
  assign illegal_instr = r_ill;
`else
  assign illegal_instr = 1'b0;
`endif
  assign state       = r_state;
  assign instr_q     = r_instr;
  assign bus_err     = r_bus;
  assign imem_req    = r_state == S_FETCH;
  assign dmem_req    = r_state == S_MEM;
  assign dmem_we     = r_state == S_MEM && w_st;
  assign pc_we       = (r_state == S_EXEC && w_br) || (r_state == S_MEM && w_st && dmem_ack) || r_state == S_WB;
  assign reg_we      = r_state == S_WB && w_known && r_instr[11:7] != 5'd0;
  assign alu_src_imm = w_known && !w_op && !w_br;
  assign pc_sel      = (w_jal || (w_br && branch_taken)) ? 2'b01 : w_jalr ? 2'b10 : 2'b00;
  assign wb_sel      = (w_jal || w_jalr) ? 2'b10 : w_lui ? 2'b11 : w_ld ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven and randomized model-checked bench for mc_control
module tb_mc_control;
  localparam int MW = 255;
  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5, K_ST = 6, K_IMM = 7, K_OP = 8, K_UNK = 9;
  logic        clk = 0, rst_n = 1;
  logic        imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, branch_taken = 0;
  logic [31:0] imem_rdata = 0, instr_q;
  logic [2:0]  state;
  logic        alu_src_imm, pc_we, reg_we, illegal_instr, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  int          n_chk = 0, n_fail = 0;

  mc_control #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
    .instr_q(instr_q), .state(state), .alu_src_imm(alu_src_imm), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .pc_we(pc_we), .reg_we(reg_we), .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        ireq, dreq, dwe, pcwe, regwe, ia, da, bt, ill, bus;
    logic [31:0] rd, iq;
  } rec_t;
  typedef struct {
    logic [31:0] ins;
    logic        bt;
    int          lat;
    logic        alu;
    logic [1:0]  pcs, wbs;
    int          rw, pw;
  } tv_t;

  rec_t        q[$];
  tv_t         tv[$];
  logic [31:0] m_iq;
  logic        m_ill, m_bus;
  logic [6:0]  opc [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int kind(input logic [6:0] o);
    case (o)
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return K_BR;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b0010011: return K_IMM;
      7'b0110011: return K_OP;
      default:    return K_UNK;
    endcase
  endfunction

  // {alu_src_imm, pc_sel, wb_sel} as the instruction-class table defines them
  function automatic logic [4:0] exp_dec(input logic [31:0] i, input logic bt);
    case (kind(i[6:0]))
      K_LUI:   return 5'b1_00_11;
      K_JAL:   return 5'b1_01_10;
      K_JALR:  return 5'b1_10_10;
      K_BR:    return {1'b0, bt ? 2'b01 : 2'b00, 2'b00};
      K_LD:    return 5'b1_00_01;
      K_OP:    return 5'b0_00_00;
      K_UNK:   return 5'b0_00_00;
      default: return 5'b1_00_00;
    endcase
  endfunction

  function automatic rec_t blank(input logic [2:0] s);
    rec_t r;
    r.st = s; r.ireq = 0; r.dreq = 0; r.dwe = 0; r.pcwe = 0; r.regwe = 0;
    r.ia = 1'($urandom); r.da = 1'($urandom); r.bt = 1'($urandom); r.rd = $urandom;
    r.iq = m_iq; r.ill = m_ill; r.bus = m_bus;
    return r;
  endfunction

  task automatic push_trap();
    repeat (3) q.push_back(blank(3'd6));
  endtask

  // expected per-cycle trace of one instruction: fetch ack after fw waits, mem ack after mw waits
  task automatic plan(input logic [31:0] ins, input int fw, input int mw);
    rec_t r;
    int   k = kind(ins[6:0]);
    for (int c = 0; c < fw + 1 && c < MW; c++) begin
      r = blank(3'd1); r.ireq = 1; r.ia = (c == fw); r.rd = (c == fw) ? ins : $urandom;
      q.push_back(r);
    end
    if (fw >= MW) begin m_bus = 1; push_trap(); return; end
    m_iq = ins;
    q.push_back(blank(3'd2));
    if (k == K_UNK) begin
`ifdef ILLEGAL_TRAP_EN
      m_ill = 1; push_trap();
`else
      r = blank(3'd5); r.pcwe = 1; q.push_back(r);
`endif
      return;
    end
    r = blank(3'd3); r.pcwe = (k == K_BR); q.push_back(r);
    if (k == K_BR) return;
    if (k == K_LD || k == K_ST) begin
      for (int c = 0; c < mw + 1 && c < MW; c++) begin
        r = blank(3'd4); r.dreq = 1; r.dwe = (k == K_ST); r.da = (c == mw); r.pcwe = (k == K_ST && c == mw);
        q.push_back(r);
      end
      if (mw >= MW) begin m_bus = 1; push_trap(); return; end
      if (k == K_ST) return;
    end
    r = blank(3'd5); r.pcwe = 1; r.regwe = (ins[11:7] != 5'd0); q.push_back(r);
  endtask

  task automatic run_q(input int lim);
    rec_t r;
    logic [4:0] d;
    for (int n = 0; n < lim && q.size() > 0; n++) begin
      r = q.pop_front();
      imem_ack = r.ia; imem_rdata = r.rd; dmem_ack = r.da; branch_taken = r.bt;
      #1;
      d = exp_dec(r.iq, r.bt);
      chk("state", state, r.st);
      chk("imem_req", imem_req, r.ireq);
      chk("dmem_req", dmem_req, r.dreq);
      chk("dmem_we", dmem_we, r.dwe);
      chk("pc_we", pc_we, r.pcwe);
      chk("reg_we", reg_we, r.regwe);
      chk("instr_q", instr_q, r.iq);
      chk("alu_src_imm", alu_src_imm, d[4]);
      chk("pc_sel", pc_sel, d[3:2]);
      chk("wb_sel", wb_sel, d[1:0]);
      chk("illegal_instr", illegal_instr, r.ill);
      chk("bus_err", bus_err, r.bus);
      @(posedge clk); #1;
    end
  endtask

  // asserts reset away from the clock edge, checks its immediate effect, releases at posedge+1
  task automatic do_reset();
    rst_n = 0; imem_ack = 0; dmem_ack = 0;
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_instr_q", instr_q, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_flags", {illegal_instr, bus_err}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    q.delete(); m_iq = 0; m_ill = 0; m_bus = 0;
    q.push_back(blank(3'd0));
  endtask

  // zero-wait run answering every request at once; measures latency and strobe counts
  task automatic run_zero(input tv_t v);
    int         n = 0, pw = 0, rw = 0;
    bit         left = 0, done = 0;
    logic       alu = 0;
    logic [1:0] pcs = 0, wbs = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      imem_ack = imem_req; imem_rdata = v.ins; dmem_ack = dmem_req; branch_taken = v.bt;
      #1;
      if (state == 3'd1 && left) done = 1;
      else begin
        left = left | (state != 3'd1);
        n++; pw += int'(pc_we); rw += int'(reg_we);
        if (state == 3'd2) begin alu = alu_src_imm; pcs = pc_sel; wbs = wb_sel; end
        @(posedge clk); #1;
      end
    end
    chk("zw_returned_to_fetch", done, 1);
    chk("zw_latency", n, v.lat);
    chk("zw_alu_src_imm", alu, v.alu);
    chk("zw_pc_sel", pcs, v.pcs);
    chk("zw_wb_sel", wbs, v.wbs);
    chk("zw_reg_we_pulses", rw, v.rw);
    chk("zw_pc_we_pulses", pw, v.pw);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  o;
    int          k;
    tv.push_back('{32'h00500093, 1'b0, 4, 1'b1, 2'b00, 2'b00, 1, 1});
    tv.push_back('{32'h0000A103, 1'b0, 5, 1'b1, 2'b00, 2'b01, 1, 1});
    tv.push_back('{32'h00000463, 1'b1, 3, 1'b0, 2'b01, 2'b00, 0, 1});
    tv.push_back('{32'h00000463, 1'b0, 3, 1'b0, 2'b00, 2'b00, 0, 1});
    tv.push_back('{32'h00000013, 1'b0, 4, 1'b1, 2'b00, 2'b00, 0, 1});
    tv.push_back('{32'h002081B3, 1'b0, 4, 1'b0, 2'b00, 2'b00, 1, 1});
    tv.push_back('{32'h123452B7, 1'b0, 4, 1'b1, 2'b00, 2'b11, 1, 1});
    tv.push_back('{32'h00001317, 1'b0, 4, 1'b1, 2'b00, 2'b00, 1, 1});
    tv.push_back('{32'h008000EF, 1'b1, 4, 1'b1, 2'b01, 2'b10, 1, 1});
    tv.push_back('{32'h000080E7, 1'b0, 4, 1'b1, 2'b10, 2'b10, 1, 1});
`ifndef ILLEGAL_TRAP_EN
    tv.push_back('{32'hFFFFFFFF, 1'b0, 3, 1'b0, 2'b00, 2'b00, 0, 1});
`endif
    tv.push_back('{32'h0020A023, 1'b0, 4, 1'b1, 2'b00, 2'b00, 0, 1});
    #2;
    do_reset();
    run_q(1);
    foreach (tv[i]) run_zero(tv[i]);
    q.delete(); m_iq = tv[tv.size() - 1].ins;
    for (int i = 0; i < 150; i++) begin
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      if (k == K_UNK) begin
        o = 7'($urandom);
        while (kind(o) != K_UNK) o = 7'($urandom);
      end else o = opc[k];
      ins = {$urandom >> 7, o};
      plan(ins, $urandom_range(0, 3), $urandom_range(0, 3));
      run_q(1 << 30);
    end
    do_reset();
    plan(32'h00500093, 0, 0);
    plan(32'h0000A103, 0, 3);
    plan(32'h00000463, 0, 0);
    plan(32'h00000013, 1, 0);
    run_q(1 << 30);
    do_reset();
    plan(32'h00500093, MW - 1, 0);
    run_q(1 << 30);
    do_reset();
    plan(32'h00500093, MW, 0);
    run_q(1 << 30);
    do_reset();
    plan(32'h0000A103, 0, MW);
    run_q(1 << 30);
    do_reset();
    plan(32'h0000A103, 0, 10);
    run_q(6);
    do_reset();
    run_q(1 << 30);
    do_reset();
    plan(32'hFFFFFFFF, 1, 0);
    plan(32'h00500093, 0, 0);
    run_q(1 << 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
